// File: rtl/async_fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ
// requesters in the write clock domain. A grant lasts up to MAX_BURST beats.
// It ends early on a packet end, or after IDLE_TIMEOUT consecutive cycles in
// which the granted requester has nothing to send. FIFO full only pauses a
// grant and never ends it.
module async_fifo_write_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int MAX_BURST    = 4,
   parameter int IDLE_TIMEOUT = 8
) (
   input  logic                          write_clk,
   input  logic                          write_rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          p_write_en,
   output logic [DATA_WIDTH-1:0]         p_write_data,
   input  logic                          p_write_full,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          grant_active
);

   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BEAT_W  = $clog2(MAX_BURST + 1);
   localparam int STALL_W = $clog2(IDLE_TIMEOUT + 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
   logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

   logic                  any_req;
   logic [IDX_W-1:0]      winner_idx;
   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  accept;
   logic                  idle_cycle;
   logic                  release_now;

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      any_req    = 1'b0;
      winner_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!any_req && req_valid[IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
            any_req    = 1'b1;
            winner_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         end
      end
   end

   // Select the granted requester's beat signals.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx_q == IDX_W'(i)) begin
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
            sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // A beat moves only when the FIFO has room; otherwise the cycle is idle or stalled by full.
   assign accept     = (state_q == ST_BURST) &&  sel_valid && !p_write_full;
   assign idle_cycle = (state_q == ST_BURST) && !sel_valid && !p_write_full;

   // Drive the FIFO write port and the per-requester handshake from the current grant.
   always_comb begin
      grant        = '0;
      req_ready    = '0;
      grant_active = 1'b0;
      p_write_en   = accept;
      p_write_data = accept ? sel_data : '0;
      if (state_q == ST_BURST) begin
         grant[grant_idx_q]     = 1'b1;
         grant_active           = 1'b1;
         req_ready[grant_idx_q] = !p_write_full;
      end
   end

   // Next-state logic: grant in IDLE, count beats and stalls in BURST, release on last/burst/timeout.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_idx_d = grant_idx_q;
      beat_cnt_d  = beat_cnt_q;
      stall_cnt_d = stall_cnt_q;
      release_now = 1'b0;
      case (state_q)
         ST_IDLE: begin
            beat_cnt_d  = '0;
            stall_cnt_d = '0;
            if (any_req) begin
               grant_idx_d = winner_idx;
               state_d     = ST_BURST;
            end
         end
         ST_BURST: begin
            if (accept) begin
               beat_cnt_d  = beat_cnt_q + BEAT_W'(1);
               stall_cnt_d = '0;
               if (sel_last || (beat_cnt_q == BEAT_W'(MAX_BURST - 1))) begin
                  release_now = 1'b1;
               end
            end else if (idle_cycle) begin
               if (stall_cnt_q == STALL_W'(IDLE_TIMEOUT - 1)) begin
                  release_now = 1'b1;
               end else begin
                  stall_cnt_d = stall_cnt_q + STALL_W'(1);
               end
            end
            if (release_now) begin
               state_d  = ST_IDLE;
               rr_ptr_d = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + IDX_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and counter registers; reset drops any burst in progress at once.
   always_ff @(posedge write_clk or negedge write_rst_n) begin
      if (!write_rst_n) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         grant_idx_q <= '0;
         beat_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_idx_q <= grant_idx_d;
         beat_cnt_q  <= beat_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_async_fifo_write_arbiter.sv
// Self-checking bench for async_fifo_write_arbiter: a transaction-level
// ownership model checked every cycle, directed scenarios with literal
// expectations, and a random phase with a per-requester ordering scoreboard.
module tb_async_fifo_write_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;
   localparam int IT = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic            p_write_en;
   logic [DW-1:0]   p_write_data;
   logic            p_write_full;
   logic [N-1:0]    grant;
   logic            grant_active;

   int n_checks = 0;
   int n_fail   = 0;
   logic rand_phase = 1'b0;

   // Model: who owns the write port, where the next search starts, and the grant's history.
   int m_owner  = -1;
   int m_ptr    = 0;
   int m_beats  = 0;
   int m_stalls = 0;
   int sb_seq [N] = '{default: 0};

   localparam logic [7:0] T2_DATA  [N] = '{8'h10, 8'h21, 8'h32, 8'h43};
   localparam int         T2_ORDER [5] = '{1, 2, 3, 0, 1};
   localparam logic [3:0] T2_GRANT [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

   async_fifo_write_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)
   ) dut (
      .write_clk   (clk),
      .write_rst_n (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .p_write_en  (p_write_en),
      .p_write_data(p_write_data),
      .p_write_full(p_write_full),
      .grant       (grant),
      .grant_active(grant_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic set_data(input int i, input logic [DW-1:0] v);
      req_data[i*DW +: DW] = v;
   endtask

   function automatic int pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_grant();
      return (m_owner < 0) ? '0 : N'(1) << m_owner;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      return (m_owner < 0 || p_write_full) ? '0 : N'(1) << m_owner;
   endfunction

   function automatic logic exp_en();
      return (m_owner >= 0) && req_valid[m_owner] && !p_write_full;
   endfunction

   function automatic logic [DW-1:0] exp_data();
      return exp_en() ? req_data[m_owner*DW +: DW] : '0;
   endfunction

   // Model update: ownership passes on the spec's release rules.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner  <= -1;
         m_ptr    <= 0;
         m_beats  <= 0;
         m_stalls <= 0;
      end else if (m_owner < 0) begin
         if (|req_valid) begin
            m_owner  <= pick(req_valid, m_ptr);
            m_beats  <= 0;
            m_stalls <= 0;
         end
      end else if (!p_write_full) begin
         if (req_valid[m_owner]) begin
            m_beats  <= m_beats + 1;
            m_stalls <= 0;
            if (req_last[m_owner] || m_beats + 1 == MB) begin
               m_owner <= -1;
               m_ptr   <= (m_owner + 1) % N;
            end
         end else begin
            m_stalls <= m_stalls + 1;
            if (m_stalls + 1 == IT) begin
               m_owner <= -1;
               m_ptr   <= (m_owner + 1) % N;
            end
         end
      end
   end

   // Compare process: DUT against model and invariants, every cycle.
   always @(negedge clk) begin
      check("grant", grant, exp_grant());
      check("grant_active", grant_active, m_owner >= 0);
      check("req_ready", req_ready, exp_ready());
      check("p_write_en", p_write_en, exp_en());
      check("p_write_data", p_write_data, exp_data());
      check("inv_en_while_full", p_write_en & p_write_full, 1'b0);
      check("inv_en_implies_active", p_write_en & !grant_active, 1'b0);
      check("inv_grant_onehot0", $onehot0(grant), 1'b1);
      check("inv_ready_popcount", $countones(req_ready) <= 1, 1'b1);
      if (rand_phase && p_write_en && m_owner >= 0) begin
         check("sb_order", p_write_data, {2'(m_owner), 6'(sb_seq[m_owner])});
         sb_seq[m_owner] <= sb_seq[m_owner] + 1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not end, actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0] acc;
      int seq [N];
      rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; p_write_full = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      at_neg();
      check("t0_reset_grant", grant, 4'b0000);
      check("t0_reset_active", grant_active, 1'b0);
      check("t0_reset_ready", req_ready, 4'b0000);
      check("t0_reset_en", p_write_en, 1'b0);
      check("t0_reset_data", p_write_data, 8'h00);

      // Test 1: requester 0 streams three beats, last on the third.
      step(); rst_n = 1'b1; req_valid = 4'b0001; set_data(0, 8'hA0);
      at_neg(); check("t1_bubble", grant, 4'b0000);
      step();
      at_neg(); check("t1_grant", grant, 4'b0001); check("t1_b0", p_write_data, 8'hA0);
      step(); set_data(0, 8'hA1);
      at_neg(); check("t1_b1_en", p_write_en, 1'b1); check("t1_b1", p_write_data, 8'hA1);
      step(); set_data(0, 8'hA2); req_last = 4'b0001;
      at_neg(); check("t1_b2_en", p_write_en, 1'b1); check("t1_b2", p_write_data, 8'hA2);

      // Test 2: all valid, no last; grants go 1,2,3,0,1 with 4 beats and a bubble each.
      step(); req_last = '0; req_valid = 4'b1111;
      for (int i = 0; i < N; i++) set_data(i, T2_DATA[i]);
      for (int g = 0; g < 5; g++) begin
         at_neg(); check("t2_bubble", grant, 4'b0000);
         step();
         for (int b = 0; b < MB; b++) begin
            at_neg();
            check("t2_grant", grant, T2_GRANT[g]);
            check("t2_en", p_write_en, 1'b1);
            check("t2_data", p_write_data, T2_DATA[T2_ORDER[g]]);
            step();
         end
      end

      // Test 3: requester 2, FIFO full for 10 cycles after two beats.
      req_valid = 4'b0100;
      at_neg(); check("t3_bubble", grant, 4'b0000);
      step();
      repeat (2) begin at_neg(); check("t3_pre_en", p_write_en, 1'b1); step(); end
      p_write_full = 1'b1;
      repeat (10) begin
         at_neg();
         check("t3_full_en", p_write_en, 1'b0);
         check("t3_full_ready", req_ready, 4'b0000);
         check("t3_full_grant", grant, 4'b0100);
         step();
      end
      p_write_full = 1'b0;
      repeat (2) begin at_neg(); check("t3_post_en", p_write_en, 1'b1); step(); end
      req_valid = '0;
      at_neg(); check("t3_released", grant, 4'b0000);

      // Test 4: requester 1 granted, then silent for IDLE_TIMEOUT cycles.
      step(); req_valid = 4'b0010;
      at_neg(); check("t4_bubble", grant, 4'b0000);
      step();
      at_neg(); check("t4_grant", grant, 4'b0010); check("t4_en", p_write_en, 1'b1);
      step(); req_valid = 4'b0100;
      repeat (IT) begin
         at_neg(); check("t4_stall_grant", grant, 4'b0010); check("t4_stall_en", p_write_en, 1'b0);
         step();
      end
      at_neg(); check("t4_timeout_release", grant, 4'b0000);
      step();
      at_neg(); check("t4_next_grant", grant, 4'b0100);

      // Test 5: asynchronous reset mid-burst at beat 2.
      step(); at_neg(); check("t5_b1_en", p_write_en, 1'b1);
      step(); at_neg(); check("t5_b2_en", p_write_en, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_grant", grant, 4'b0000);
      check("t5_rst_active", grant_active, 1'b0);
      check("t5_rst_ready", req_ready, 4'b0000);
      check("t5_rst_en", p_write_en, 1'b0);
      check("t5_rst_data", p_write_data, 8'h00);
      step(); step(); rst_n = 1'b1; req_valid = 4'b1111;
      at_neg(); check("t5_bubble", grant, 4'b0000);
      step();
      at_neg(); check("t5_restart_grant", grant, 4'b0001);

      // Test 6: random traffic and random full with an ordering scoreboard.
      step(); rst_n = 1'b0; req_valid = '0; req_last = '0;
      step(); step();
      for (int i = 0; i < N; i++) seq[i] = 0;
      rand_phase = 1'b1;
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            req_valid[i] = ($urandom_range(0, 9) < 7);
            set_data(i, {2'(i), 6'(seq[i])});
            req_last[i] = ($urandom_range(0, 3) == 0);
         end
         p_write_full = ($urandom_range(0, 4) == 0);
         at_neg();
         acc = req_valid & req_ready;
         step();
         for (int i = 0; i < N; i++) if (acc[i]) seq[i]++;
      end
      req_valid = '0; p_write_full = 1'b0;
      repeat (IT + 4) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
